// File: rtl/wb_burst_master.sv
// wb_burst_master: Wishbone B4 registered-feedback burst master.
// Accepts one command (address, beat count, direction, burst type) and runs
// it as a single Wishbone cycle, streaming write data in or read data out.
// Optional build macro WB_BURST_MASTER_TIMEOUT_EN adds a stall watchdog that
// aborts the burst after TIMEOUT_CYCLES consecutive unanswered strobes.
module wb_burst_master #(
  parameter int dw             = 32,
  parameter int aw             = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_i,
  // command port
  input  logic          cmd_valid_i,
  output logic          cmd_ready_o,
  input  logic [aw-1:0] cmd_adr_i,
  input  logic [3:0]    cmd_len_i,
  input  logic          cmd_we_i,
  input  logic [1:0]    cmd_bte_i,
  // write-data port
  input  logic [dw-1:0] wr_dat_i,
  input  logic          wr_valid_i,
  output logic          wr_ready_o,
  // read-data port
  output logic [dw-1:0] rd_dat_o,
  output logic          rd_valid_o,
  // status
  output logic          done_o,
  output logic          err_o,
  // wishbone master
  output logic [aw-1:0] wb_adr_o,
  output logic [dw-1:0] wb_dat_o,
  output logic [3:0]    wb_sel_o,
  output logic          wb_we_o,
  output logic [1:0]    wb_bte_o,
  output logic [2:0]    wb_cti_o,
  output logic          wb_cyc_o,
  output logic          wb_stb_o,
  input  logic [dw-1:0] wb_dat_i,
  input  logic          wb_ack_i,
  input  logic          wb_err_i,
  input  logic          wb_rty_i
);

  typedef enum logic [1:0] {IDLE, ACTIVE, FINISH} state_t;

  state_t        state_q, state_d;
  logic [aw-3:0] adr_q, adr_d;       // word address of the current beat
  logic [4:0]    rem_q, rem_d;       // beats still to complete (1..16)
  logic          we_q, we_d;
  logic [1:0]    bte_q, bte_d;
  logic          single_q, single_d; // command was a single-beat transfer
  logic          err_q, err_d;       // burst ended by an abort

  logic          active_w;
  logic          stb_w;
  logic          abort_w;
  logic          beat_w;
  logic          last_w;
  logic          timeout_w;
  logic [aw-3:0] wrap_mask_w;
  logic [aw-3:0] adr_inc_w;
  logic [aw-3:0] adr_next_w;

  // The two address bits below word granularity are always forced to zero.
  logic unused_bits;
  assign unused_bits = ^cmd_adr_i[1:0];

  assign active_w = (state_q == ACTIVE);
  // Writes only strobe when data is available; a low strobe is a wait state.
  assign stb_w    = active_w & (we_q ? wr_valid_i : 1'b1);
  // Error, retry or watchdog all end the burst; they win over a coincident ack.
  assign abort_w  = stb_w & (wb_err_i | wb_rty_i | timeout_w);
  assign beat_w   = stb_w & wb_ack_i & ~abort_w;
  assign last_w   = (rem_q == 5'd1);

`ifdef WB_BURST_MASTER_TIMEOUT_EN
  logic [7:0] to_cnt_q, to_cnt_d;
  logic       stall_w;

  assign stall_w   = stb_w & ~(wb_ack_i | wb_err_i | wb_rty_i);
  // Fires on the stalled cycle that brings the count to TIMEOUT_CYCLES.
  assign timeout_w = stall_w & (to_cnt_q == 8'(TIMEOUT_CYCLES - 1));

  // Watchdog counts consecutive unanswered strobes; any response clears it.
  always_comb begin
    to_cnt_d = 8'd0;
    if (stall_w) to_cnt_d = to_cnt_q + 8'd1;
  end

  // Watchdog counter register.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) to_cnt_q <= 8'd0;
    else          to_cnt_q <= to_cnt_d;
  end
`else
  // Without the watchdog the master waits for the slave indefinitely.
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES == 0);
  assign timeout_w      = 1'b0;
`endif

  // Burst-type wrap: only the masked low word-address bits increment.
  always_comb begin
    wrap_mask_w = '0;
    case (bte_q)
      2'b01:   wrap_mask_w[1:0] = 2'b11;
      2'b10:   wrap_mask_w[2:0] = 3'b111;
      2'b11:   wrap_mask_w[3:0] = 4'b1111;
      default: wrap_mask_w      = '1;
    endcase
  end

  assign adr_inc_w  = adr_q + 1'b1;
  assign adr_next_w = (adr_q & ~wrap_mask_w) | (adr_inc_w & wrap_mask_w);

  // State register; reset overrides every other event.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cmd_valid_i) state_d = ACTIVE;
      ACTIVE:  if (abort_w || (beat_w && last_w)) state_d = FINISH;
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Command capture and per-beat bookkeeping.
  always_comb begin
    adr_d    = adr_q;
    rem_d    = rem_q;
    we_d     = we_q;
    bte_d    = bte_q;
    single_d = single_q;
    err_d    = err_q;
    if (state_q == IDLE && cmd_valid_i) begin
      adr_d    = cmd_adr_i[aw-1:2];
      rem_d    = (cmd_len_i == 4'd0) ? 5'd16 : {1'b0, cmd_len_i};
      we_d     = cmd_we_i;
      bte_d    = cmd_bte_i;
      single_d = (cmd_len_i == 4'd1);
      err_d    = 1'b0;
    end else if (abort_w) begin
      err_d = 1'b1;
    end else if (beat_w) begin
      adr_d = adr_next_w;
      rem_d = rem_q - 5'd1;
    end
  end

  // Datapath registers.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      adr_q    <= '0;
      rem_q    <= 5'd0;
      we_q     <= 1'b0;
      bte_q    <= 2'b00;
      single_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      adr_q    <= adr_d;
      rem_q    <= rem_d;
      we_q     <= we_d;
      bte_q    <= bte_d;
      single_q <= single_d;
      err_q    <= err_d;
    end
  end

  // Output decode from state and current-cycle bus responses.
  always_comb begin
    cmd_ready_o = (state_q == IDLE);
    wb_cyc_o    = active_w;
    wb_stb_o    = stb_w;
    wb_we_o     = active_w & we_q;
    wb_bte_o    = active_w ? bte_q : 2'b00;
    wb_sel_o    = active_w ? 4'hf : 4'h0;
    wb_cti_o    = 3'b000;
    if (active_w && !single_q) wb_cti_o = last_w ? 3'b111 : 3'b010;
    wb_adr_o    = {adr_q, 2'b00};
    wb_dat_o    = wr_dat_i;
    wr_ready_o  = beat_w & we_q;
    rd_dat_o    = wb_dat_i;
    rd_valid_o  = beat_w & ~we_q;
    done_o      = (state_q == FINISH);
    err_o       = (state_q == FINISH) & err_q;
  end

endmodule

// File: tb/tb_wb_burst_master.sv
// tb_wb_burst_master: table-driven per-cycle vectors for the main burst
// patterns plus hand-written sequences for wait states, error abort, reset
// mid-burst and (when WB_BURST_MASTER_TIMEOUT_EN is defined) the watchdog.
module tb_wb_burst_master;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i;
  logic        cmd_valid_i, cmd_ready_o;
  logic [31:0] cmd_adr_i;
  logic [3:0]  cmd_len_i;
  logic        cmd_we_i;
  logic [1:0]  cmd_bte_i;
  logic [31:0] wr_dat_i;
  logic        wr_valid_i, wr_ready_o;
  logic [31:0] rd_dat_o;
  logic        rd_valid_o, done_o, err_o;
  logic [31:0] wb_adr_o, wb_dat_o;
  logic [3:0]  wb_sel_o;
  logic        wb_we_o;
  logic [1:0]  wb_bte_o;
  logic [2:0]  wb_cti_o;
  logic        wb_cyc_o, wb_stb_o;
  logic [31:0] wb_dat_i;
  logic        wb_ack_i, wb_err_i, wb_rty_i;

  int total = 0;
  int bad   = 0;

  always #5 wb_clk_i = ~wb_clk_i;

  wb_burst_master dut (
    .wb_clk_i   (wb_clk_i),
    .wb_rst_i   (wb_rst_i),
    .cmd_valid_i(cmd_valid_i),
    .cmd_ready_o(cmd_ready_o),
    .cmd_adr_i  (cmd_adr_i),
    .cmd_len_i  (cmd_len_i),
    .cmd_we_i   (cmd_we_i),
    .cmd_bte_i  (cmd_bte_i),
    .wr_dat_i   (wr_dat_i),
    .wr_valid_i (wr_valid_i),
    .wr_ready_o (wr_ready_o),
    .rd_dat_o   (rd_dat_o),
    .rd_valid_o (rd_valid_o),
    .done_o     (done_o),
    .err_o      (err_o),
    .wb_adr_o   (wb_adr_o),
    .wb_dat_o   (wb_dat_o),
    .wb_sel_o   (wb_sel_o),
    .wb_we_o    (wb_we_o),
    .wb_bte_o   (wb_bte_o),
    .wb_cti_o   (wb_cti_o),
    .wb_cyc_o   (wb_cyc_o),
    .wb_stb_o   (wb_stb_o),
    .wb_dat_i   (wb_dat_i),
    .wb_ack_i   (wb_ack_i),
    .wb_err_i   (wb_err_i),
    .wb_rty_i   (wb_rty_i)
  );

  typedef struct {
    logic        cv;
    logic [31:0] cadr;
    logic [3:0]  clen;
    logic        cwe;
    logic [1:0]  cbte;
    logic        wv;
    logic        ack;
    logic        err;
    logic        rty;
    logic [31:0] dat;
    logic        e_rdy;
    logic        e_cyc;
    logic        e_stb;
    logic        e_we;
    logic [1:0]  e_bte;
    logic [31:0] e_adr;
    logic [2:0]  e_cti;
    logic        e_wrr;
    logic        e_rdv;
    logic        e_done;
    logic        e_err;
  } vec_t;

  vec_t vecs [0:17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge wb_clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    cmd_valid_i = 1'b0; cmd_adr_i = 32'h0; cmd_len_i = 4'd0; cmd_we_i = 1'b0;
    cmd_bte_i = 2'd0; wr_dat_i = 32'h0; wr_valid_i = 1'b0; wb_dat_i = 32'h0;
    wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_rty_i = 1'b0;
  endtask

  task automatic send_cmd(input logic [31:0] adr, input logic [3:0] len,
                          input logic we, input logic [1:0] bte);
    cmd_valid_i = 1'b1; cmd_adr_i = adr; cmd_len_i = len; cmd_we_i = we; cmd_bte_i = bte;
    @(negedge wb_clk_i);
    chk("cmd_accept_rdy", 32'(cmd_ready_o), 32'd1);
    tick();
    cmd_valid_i = 1'b0;
  endtask

  initial begin
    int nrd;
    int nack;
    int stalls;

    // cv cadr clen cwe cbte | wv ack err rty dat | rdy cyc stb we bte adr cti wrr rdv done err
    // read 0x100 x4 linear
    vecs[0]  = '{1'b1,32'h100,4'd4,1'b0,2'd0, 1'b0,1'b0,1'b0,1'b0,32'h0,  1'b1,1'b0,1'b0,1'b0,2'd0,32'h0,  3'b000,1'b0,1'b0,1'b0,1'b0};
    vecs[1]  = '{1'b0,32'h0,4'd0,1'b0,2'd0,   1'b0,1'b1,1'b0,1'b0,32'hA1, 1'b0,1'b1,1'b1,1'b0,2'd0,32'h100,3'b010,1'b0,1'b1,1'b0,1'b0};
    vecs[2]  = '{1'b0,32'h0,4'd0,1'b0,2'd0,   1'b0,1'b1,1'b0,1'b0,32'hA2, 1'b0,1'b1,1'b1,1'b0,2'd0,32'h104,3'b010,1'b0,1'b1,1'b0,1'b0};
    vecs[3]  = '{1'b0,32'h0,4'd0,1'b0,2'd0,   1'b0,1'b1,1'b0,1'b0,32'hA3, 1'b0,1'b1,1'b1,1'b0,2'd0,32'h108,3'b010,1'b0,1'b1,1'b0,1'b0};
    vecs[4]  = '{1'b0,32'h0,4'd0,1'b0,2'd0,   1'b0,1'b1,1'b0,1'b0,32'hA4, 1'b0,1'b1,1'b1,1'b0,2'd0,32'h10C,3'b111,1'b0,1'b1,1'b0,1'b0};
    vecs[5]  = '{1'b0,32'h0,4'd0,1'b0,2'd0,   1'b0,1'b0,1'b0,1'b0,32'h0,  1'b0,1'b0,1'b0,1'b0,2'd0,32'h0,  3'b000,1'b0,1'b0,1'b1,1'b0};
    // write 0x1C x4, 4-beat wrap
    vecs[6]  = '{1'b1,32'h1C,4'd4,1'b1,2'd1,  1'b1,1'b0,1'b0,1'b0,32'h0,  1'b1,1'b0,1'b0,1'b0,2'd0,32'h0,  3'b000,1'b0,1'b0,1'b0,1'b0};
    vecs[7]  = '{1'b0,32'h0,4'd0,1'b0,2'd0,   1'b1,1'b1,1'b0,1'b0,32'hB1, 1'b0,1'b1,1'b1,1'b1,2'd1,32'h1C, 3'b010,1'b1,1'b0,1'b0,1'b0};
    vecs[8]  = '{1'b0,32'h0,4'd0,1'b0,2'd0,   1'b1,1'b1,1'b0,1'b0,32'hB2, 1'b0,1'b1,1'b1,1'b1,2'd1,32'h10, 3'b010,1'b1,1'b0,1'b0,1'b0};
    vecs[9]  = '{1'b0,32'h0,4'd0,1'b0,2'd0,   1'b1,1'b1,1'b0,1'b0,32'hB3, 1'b0,1'b1,1'b1,1'b1,2'd1,32'h14, 3'b010,1'b1,1'b0,1'b0,1'b0};
    vecs[10] = '{1'b0,32'h0,4'd0,1'b0,2'd0,   1'b1,1'b1,1'b0,1'b0,32'hB4, 1'b0,1'b1,1'b1,1'b1,2'd1,32'h18, 3'b111,1'b1,1'b0,1'b0,1'b0};
    vecs[11] = '{1'b0,32'h0,4'd0,1'b0,2'd0,   1'b0,1'b0,1'b0,1'b0,32'h0,  1'b0,1'b0,1'b0,1'b0,2'd0,32'h0,  3'b000,1'b0,1'b0,1'b1,1'b0};
    // read 0x3E (low bits dropped) x2, 8-beat wrap, slave wait, then ack+rty abort
    vecs[12] = '{1'b1,32'h3E,4'd2,1'b0,2'd2,  1'b0,1'b0,1'b0,1'b0,32'h0,  1'b1,1'b0,1'b0,1'b0,2'd0,32'h0,  3'b000,1'b0,1'b0,1'b0,1'b0};
    vecs[13] = '{1'b1,32'h500,4'd1,1'b1,2'd3, 1'b0,1'b0,1'b0,1'b0,32'h0,  1'b0,1'b1,1'b1,1'b0,2'd2,32'h3C, 3'b010,1'b0,1'b0,1'b0,1'b0};
    vecs[14] = '{1'b0,32'h0,4'd0,1'b0,2'd0,   1'b0,1'b1,1'b0,1'b0,32'hC1, 1'b0,1'b1,1'b1,1'b0,2'd2,32'h3C, 3'b010,1'b0,1'b1,1'b0,1'b0};
    vecs[15] = '{1'b0,32'h0,4'd0,1'b0,2'd0,   1'b0,1'b1,1'b0,1'b1,32'hC2, 1'b0,1'b1,1'b1,1'b0,2'd2,32'h20, 3'b111,1'b0,1'b0,1'b0,1'b0};
    vecs[16] = '{1'b1,32'h700,4'd3,1'b0,2'd0, 1'b0,1'b0,1'b0,1'b0,32'h0,  1'b0,1'b0,1'b0,1'b0,2'd0,32'h0,  3'b000,1'b0,1'b0,1'b1,1'b1};
    vecs[17] = '{1'b0,32'h0,4'd0,1'b0,2'd0,   1'b0,1'b0,1'b0,1'b0,32'h0,  1'b1,1'b0,1'b0,1'b0,2'd0,32'h0,  3'b000,1'b0,1'b0,1'b0,1'b0};

    idle_inputs();
    wb_rst_i = 1'b1;
    repeat (3) @(posedge wb_clk_i);
    #1 wb_rst_i = 1'b0;

    // reset state
    @(negedge wb_clk_i);
    chk("rst_rdy",  32'(cmd_ready_o), 32'd1);
    chk("rst_cyc",  32'(wb_cyc_o),    32'd0);
    chk("rst_stb",  32'(wb_stb_o),    32'd0);
    chk("rst_adr",  wb_adr_o,         32'h0);
    chk("rst_cti",  32'(wb_cti_o),    32'd0);
    chk("rst_done", 32'(done_o),      32'd0);
    chk("rst_err",  32'(err_o),       32'd0);
    chk("rst_wrr",  32'(wr_ready_o),  32'd0);
    chk("rst_rdv",  32'(rd_valid_o),  32'd0);
    $display("reset released: rdy=%b cyc=%b", cmd_ready_o, wb_cyc_o);
    tick();

    for (int i = 0; i < 18; i++) begin
      cmd_valid_i = vecs[i].cv;  cmd_adr_i = vecs[i].cadr; cmd_len_i = vecs[i].clen;
      cmd_we_i    = vecs[i].cwe; cmd_bte_i = vecs[i].cbte; wr_valid_i = vecs[i].wv;
      wb_ack_i    = vecs[i].ack; wb_err_i  = vecs[i].err;  wb_rty_i   = vecs[i].rty;
      wr_dat_i    = vecs[i].dat; wb_dat_i  = vecs[i].dat;
      @(negedge wb_clk_i);
      $display("vec %0d: cyc=%b stb=%b adr=%h cti=%b wrr=%b rdv=%b done=%b err=%b",
               i, wb_cyc_o, wb_stb_o, wb_adr_o, wb_cti_o, wr_ready_o, rd_valid_o, done_o, err_o);
      chk($sformatf("v%0d rdy", i),  32'(cmd_ready_o), 32'(vecs[i].e_rdy));
      chk($sformatf("v%0d cyc", i),  32'(wb_cyc_o),    32'(vecs[i].e_cyc));
      chk($sformatf("v%0d stb", i),  32'(wb_stb_o),    32'(vecs[i].e_stb));
      chk($sformatf("v%0d we", i),   32'(wb_we_o),     32'(vecs[i].e_we));
      chk($sformatf("v%0d bte", i),  32'(wb_bte_o),    32'(vecs[i].e_bte));
      chk($sformatf("v%0d cti", i),  32'(wb_cti_o),    32'(vecs[i].e_cti));
      chk($sformatf("v%0d wrr", i),  32'(wr_ready_o),  32'(vecs[i].e_wrr));
      chk($sformatf("v%0d rdv", i),  32'(rd_valid_o),  32'(vecs[i].e_rdv));
      chk($sformatf("v%0d done", i), 32'(done_o),      32'(vecs[i].e_done));
      chk($sformatf("v%0d err", i),  32'(err_o),       32'(vecs[i].e_err));
      if (vecs[i].e_cyc) begin
        chk($sformatf("v%0d adr", i), wb_adr_o,         vecs[i].e_adr);
        chk($sformatf("v%0d sel", i), 32'(wb_sel_o),    32'hf);
      end
      if (vecs[i].e_rdv) chk($sformatf("v%0d rdat", i), rd_dat_o, vecs[i].dat);
      if (vecs[i].e_wrr) chk($sformatf("v%0d wdat", i), wb_dat_o, vecs[i].dat);
      tick();
    end
    idle_inputs();

    // single-beat write with three cycles of wr_valid low; acks while stb low ignored
    send_cmd(32'h40, 4'd1, 1'b1, 2'd0);
    wb_ack_i = 1'b1;
    nack = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge wb_clk_i);
      chk("w1_wait_cyc", 32'(wb_cyc_o),   32'd1);
      chk("w1_wait_stb", 32'(wb_stb_o),   32'd0);
      chk("w1_wait_wrr", 32'(wr_ready_o), 32'd0);
      chk("w1_wait_adr", wb_adr_o,        32'h40);
      chk("w1_wait_cti", 32'(wb_cti_o),   32'd0);
      tick();
    end
    wr_valid_i = 1'b1; wr_dat_i = 32'hD00D_F00D;
    @(negedge wb_clk_i);
    chk("w1_stb",  32'(wb_stb_o),   32'd1);
    chk("w1_wrr",  32'(wr_ready_o), 32'd1);
    chk("w1_cti",  32'(wb_cti_o),   32'd0);
    chk("w1_wdat", wb_dat_o,        32'hD00D_F00D);
    nack += int'(wr_ready_o);
    tick();
    wr_valid_i = 1'b0;
    @(negedge wb_clk_i);
    chk("w1_done", 32'(done_o),   32'd1);
    chk("w1_err",  32'(err_o),    32'd0);
    chk("w1_cyc",  32'(wb_cyc_o), 32'd0);
    chk("w1_nack", 32'(nack),     32'd1);
    $display("single write: acks=%0d done=%b", nack, done_o);
    tick();
    idle_inputs();

    // 16-beat read with err (coincident with ack) on beat 5
    send_cmd(32'h300, 4'd0, 1'b0, 2'd0);
    nrd = 0;
    for (int b = 1; b <= 5; b++) begin
      wb_ack_i = 1'b1;
      wb_err_i = (b == 5);
      @(negedge wb_clk_i);
      nrd += int'(rd_valid_o);
      chk($sformatf("r16 b%0d cyc", b), 32'(wb_cyc_o), 32'd1);
      chk($sformatf("r16 b%0d cti", b), 32'(wb_cti_o), 32'b010);
      chk($sformatf("r16 b%0d adr", b), wb_adr_o,      32'h300 + 32'(4 * (b - 1)));
      tick();
    end
    wb_ack_i = 1'b0; wb_err_i = 1'b0;
    @(negedge wb_clk_i);
    chk("r16_nrd",  32'(nrd),      32'd4);
    chk("r16_done", 32'(done_o),   32'd1);
    chk("r16_err",  32'(err_o),    32'd1);
    chk("r16_cyc",  32'(wb_cyc_o), 32'd0);
    $display("err abort read: beats=%0d done=%b err=%b", nrd, done_o, err_o);
    tick();

    // reset asserted during beat 2 of an 8-beat read
    send_cmd(32'h200, 4'd8, 1'b0, 2'd0);
    wb_ack_i = 1'b1;
    @(negedge wb_clk_i);
    chk("rr_b1_rdv", 32'(rd_valid_o), 32'd1);
    tick();
    wb_rst_i = 1'b1;
    tick();
    wb_ack_i = 1'b0;
    @(negedge wb_clk_i);
    chk("rr_cyc",  32'(wb_cyc_o), 32'd0);
    chk("rr_stb",  32'(wb_stb_o), 32'd0);
    chk("rr_done", 32'(done_o),   32'd0);
    chk("rr_err",  32'(err_o),    32'd0);
    tick();
    wb_rst_i = 1'b0;
    @(negedge wb_clk_i);
    chk("rr_rdy",   32'(cmd_ready_o), 32'd1);
    chk("rr_done2", 32'(done_o),      32'd0);
    chk("rr_adr",   wb_adr_o,         32'h0);
    $display("reset mid-burst: cyc=%b rdy=%b", wb_cyc_o, cmd_ready_o);
    tick();

`ifdef WB_BURST_MASTER_TIMEOUT_EN
    // slave never answers: watchdog aborts after 255 stalled strobes
    send_cmd(32'h600, 4'd1, 1'b0, 2'd0);
    stalls = 0;
    for (int k = 0; k < 400; k++) begin
      @(negedge wb_clk_i);
      if (done_o) break;
      stalls += int'(wb_stb_o);
      tick();
    end
    chk("to_done",   32'(done_o), 32'd1);
    chk("to_err",    32'(err_o),  32'd1);
    chk("to_stalls", 32'(stalls), 32'd255);
    $display("timeout: stalls=%0d err=%b", stalls, err_o);
    tick();
`else
    stalls = 0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wb_burst_master.md
WB_BURST_MASTER -- requirements
Module: wb_burst_master

Interface
REQ-001 Parameters SHALL be: dw, 32, data width; aw, 32, address width; TIMEOUT_CYCLES, 255, watchdog limit (used only with the macro in REQ-027).
REQ-002 Clock and reset SHALL be: wb_clk_i  in  1  single clock, all logic on rising edge; wb_rst_i  in  1  synchronous, active-high reset.
REQ-003 Command port SHALL be: cmd_valid_i in 1 command offered; cmd_ready_o out 1 command accepted; cmd_adr_i in aw byte start address, bits [1:0] ignored; cmd_len_i in 4 beat count, 0 encodes 16; cmd_we_i in 1 write=1/read=0; cmd_bte_i in 2 burst type extension.
REQ-004 Write-data port SHALL be: wr_dat_i in dw write data; wr_valid_i in 1 data available; wr_ready_o out 1 data consumed this cycle.
REQ-005 Read-data port SHALL be: rd_dat_o out dw read data; rd_valid_o out 1 read beat valid, no backpressure.
REQ-006 Status SHALL be: done_o out 1 one-cycle completion pulse; err_o out 1 one-cycle error pulse, coincident with done_o.
REQ-007 Wishbone master SHALL be: wb_adr_o out aw; wb_dat_o out dw; wb_sel_o out 4; wb_we_o out 1; wb_bte_o out 2; wb_cti_o out 3; wb_cyc_o out 1; wb_stb_o out 1; wb_dat_i in dw; wb_ack_i in 1; wb_err_i in 1; wb_rty_i in 1.

Function
REQ-008 States SHALL be IDLE, ACTIVE, FINISH; cmd_ready_o=1 only in IDLE.
REQ-009 IDLE->ACTIVE on cmd_valid_i&cmd_ready_o; cmd_adr_i (bits [1:0] forced 0), beat count, we and bte SHALL be registered that edge.
REQ-010 In ACTIVE wb_cyc_o SHALL be 1; wb_stb_o=1 for reads, =wr_valid_i for writes (stb low is a master wait state, address held).
REQ-011 wb_sel_o SHALL be 4'hf; wb_we_o and wb_bte_o SHALL hold the registered command values throughout ACTIVE.
REQ-012 wb_cti_o SHALL be 3'b000 for single-beat commands; for multi-beat, 3'b010 on every beat except the last, which SHALL be 3'b111.
REQ-013 A beat completes on wb_ack_i&wb_stb_o; wb_ack_i while stb low SHALL be ignored.
REQ-014 On beat completion the word address SHALL advance the next cycle: bte 00 linear +1; 01 wraps within bits [1:0]; 10 within [2:0]; 11 within [3:0]; upper bits unchanged.
REQ-015 Linear bursts SHALL wrap modulo 2^(aw-2) words without error.
REQ-016 Write: wb_dat_o=wr_dat_i combinationally; wr_ready_o=wb_ack_i&wb_stb_o&we in ACTIVE, else 0.
REQ-017 Read: rd_dat_o=wb_dat_i, rd_valid_o=wb_ack_i&wb_stb_o&!we in ACTIVE, else 0.
REQ-018 On completion of the last beat the next state SHALL be FINISH: cyc/stb low, done_o=1 for that one cycle, then IDLE.
REQ-019 wb_err_i or wb_rty_i while stb high SHALL abort: no data transferred that cycle (wr_ready_o=0, rd_valid_o=0), FINISH next with done_o=1 and err_o=1.
REQ-020 Simultaneous ack and err SHALL be treated as err.
REQ-021 cmd_valid_i during ACTIVE/FINISH SHALL be ignored (held by source); new command accepted earliest the cycle after FINISH.
REQ-022 Outside ACTIVE: wb_cyc_o, wb_stb_o, wb_we_o, wb_cti_o, wb_bte_o SHALL be 0.

Reset
REQ-023 Reset SHALL force IDLE, clear beat counter and address.
REQ-024 Reset values: cmd_ready_o=1 (once released), all other outputs 0.
REQ-025 Reset mid-burst SHALL drop cyc/stb the next cycle without done_o or err_o.
REQ-026 Reset SHALL dominate all other events in the same cycle.

Configuration
REQ-027 With WB_BURST_MASTER_TIMEOUT_EN defined, an 8-bit counter SHALL count ACTIVE cycles with stb high and no ack/err/rty, clearing on any of them; reaching TIMEOUT_CYCLES SHALL abort as REQ-019.
REQ-028 Without WB_BURST_MASTER_TIMEOUT_EN, no counter exists and the master SHALL wait indefinitely.

Verification
REQ-029 Read cmd adr 0x100, len 4, bte 00, slave ack every cycle -> adr 0x100,0x104,0x108,0x10C; cti 010,010,010,111; four rd_valid_o; done_o one cycle after last ack.
REQ-030 Write cmd adr 0x1C, len 4, bte 01 -> adr 0x1C,0x10,0x14,0x18; wr_ready_o on each ack; err_o=0.
REQ-031 Write len 1, wr_valid_i low 3 cycles then high -> stb low 3 cycles, cti 000, single ack, done_o.
REQ-032 Read len 0 (16), wb_err_i on beat 5 -> 4 rd_valid_o only, done_o and err_o together, cyc low next cycle.
REQ-033 Reset asserted during beat 2 of 8-beat read -> cyc/stb 0 next cycle, no done_o, cmd_ready_o=1 after release.
REQ-034 With WB_BURST_MASTER_TIMEOUT_EN, slave never acks -> err_o and done_o after 255 stalled cycles.
